// File: rtl/upsample_read_ctrl_pkg.sv
// Shared constants and FSM encoding for the 2x nearest-neighbour upsample read controller.
package upsample_read_ctrl_pkg;

    localparam int unsigned UPS_DATA_R     = 128;
    localparam int unsigned UPS_DEPTH_R    = 11;
    localparam int unsigned UPS_ROWS_W     = 10;
    localparam int unsigned UPS_SWITCH_CYC = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ROW,
        ST_READ,
        ST_SWITCH,
        ST_DONE
    } ups_state_e;

endpackage

// File: rtl/upsample_read_ctrl_if.sv
// FIFO read-side and upsampled output stream signals of the upsample read controller.
interface upsample_read_ctrl_if
    import upsample_read_ctrl_pkg::*;
#(
    parameter int unsigned DATA_R  = UPS_DATA_R,
    parameter int unsigned DEPTH_R = UPS_DEPTH_R
);

    logic               fifo_rden;
    logic [DATA_R-1:0]  fifo_rddata;
    logic               fifo_change_point;
    logic [DEPTH_R-1:0] fifo_empty_thr;
    logic               fifo_ready_for_output;
    logic               fifo_empty;

    logic [DATA_R-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_row_last;
    logic               out_frame_last;

    modport master (
        output fifo_rden, fifo_change_point, fifo_empty_thr,
        input  fifo_rddata, fifo_ready_for_output, fifo_empty,
        output out_data, out_valid, out_row_last, out_frame_last,
        input  out_ready
    );

    modport slave (
        input  fifo_rden, fifo_change_point, fifo_empty_thr,
        output fifo_rddata, fifo_ready_for_output, fifo_empty,
        input  out_data, out_valid, out_row_last, out_frame_last,
        output out_ready
    );

endinterface

// File: rtl/upsample_dup_buf.sv
// Two-entry output buffer; every stored word is presented as two consecutive beats.
module upsample_dup_buf
    import upsample_read_ctrl_pkg::*;
#(
    parameter int unsigned DATA_R = UPS_DATA_R
) (
    input  logic              system_clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_R-1:0] i_data,
    output logic              o_not_full,
    output logic              o_valid,
    output logic [DATA_R-1:0] o_data,
    input  logic              i_ready
);

    logic [DATA_R-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic              r_dup;
    logic [1:0]        r_count;
    logic              w_beat;
    logic              w_free;

    assign o_valid    = (r_count != 2'd0);
    assign o_data     = r_mem[r_rd_ptr];
    assign o_not_full = (r_count != 2'd2);
    assign w_beat     = o_valid & i_ready;
    // An entry is released only once its second (duplicate) beat is accepted.
    assign w_free     = w_beat & r_dup;

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_dup    <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_beat) begin
                r_dup <= ~r_dup;
                if (r_dup) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
            case ({i_push, w_free})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/upsample_read_ctrl.sv
// Read-side controller: each row is read twice (virtual then real pointer) and each word is
// emitted twice, producing a 2x nearest-neighbour upsampled stream.
module upsample_read_ctrl
    import upsample_read_ctrl_pkg::*;
#(
    parameter int unsigned DATA_R  = UPS_DATA_R,
    parameter int unsigned DEPTH_R = UPS_DEPTH_R,
    parameter int unsigned ROWS_W  = UPS_ROWS_W
) (
    input  logic                 system_clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DEPTH_R-1:0]   row_words,
    input  logic [ROWS_W-1:0]    row_num,
    upsample_read_ctrl_if.master bus,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned         SW_W    = $clog2(UPS_SWITCH_CYC);
    localparam logic [SW_W-1:0]     SW_LAST = SW_W'(UPS_SWITCH_CYC - 1);
    localparam logic [SW_W-1:0]     SW_ONE  = SW_W'(1);
    localparam logic [DEPTH_R:0]    CNT_ONE = (DEPTH_R + 1)'(1);
    localparam logic [ROWS_W-1:0]   ROW_ONE = ROWS_W'(1);

    ups_state_e         r_state;
    ups_state_e         w_next;
    logic               r_psel;
    logic [DEPTH_R-1:0] r_row_words;
    logic [ROWS_W-1:0]  r_row_num;
    logic [ROWS_W-1:0]  r_row_cnt;
    logic [DEPTH_R:0]   r_rd_cnt;
    logic [DEPTH_R:0]   r_beat_cnt;
    logic [SW_W-1:0]    r_sw_cnt;

    logic [DEPTH_R:0]   w_row_beats;
    logic               w_buf_not_full;
    logic               w_rden;
    logic               w_beat;
    logic               w_drained;
    logic               w_last_row;
    logic               w_row_last;

    assign w_row_beats = {r_row_words, 1'b0};
    assign w_beat      = bus.out_valid & bus.out_ready;
    assign w_drained   = (r_rd_cnt == {1'b0, r_row_words}) && (r_beat_cnt == w_row_beats);
    assign w_last_row  = (r_row_cnt == r_row_num - ROW_ONE);
    assign w_row_last  = bus.out_valid && (r_beat_cnt == w_row_beats - CNT_ONE);

    upsample_dup_buf #(.DATA_R(DATA_R)) u_dup_buf (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .i_push     (w_rden),
        .i_data     (bus.fifo_rddata),
        .o_not_full (w_buf_not_full),
        .o_valid    (bus.out_valid),
        .o_data     (bus.out_data),
        .i_ready    (bus.out_ready)
    );

    always_comb begin
        w_next                 = r_state;
        w_rden                 = 1'b0;
        bus.fifo_rden          = 1'b0;
        bus.fifo_change_point  = 1'b0;
        bus.fifo_empty_thr     = r_row_words;
        bus.out_row_last       = 1'b0;
        bus.out_frame_last     = 1'b0;
        busy                   = (r_state != ST_IDLE);
        done                   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ((row_words == '0) || (row_num == '0)) ? ST_DONE : ST_WAIT_ROW;
                end
            end
            ST_WAIT_ROW: begin
                // Pass 2 re-reads a row already resident, so only pass 1 waits on the threshold.
                if (r_psel || !bus.fifo_ready_for_output) begin
                    w_next = ST_READ;
                end
            end
            ST_READ: begin
                w_rden             = w_buf_not_full & ~bus.fifo_empty &
                                     (r_rd_cnt < {1'b0, r_row_words});
                bus.fifo_rden      = w_rden;
                bus.out_row_last   = w_row_last;
                bus.out_frame_last = w_row_last & r_psel & w_last_row;
                if (w_drained) begin
                    w_next = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                bus.fifo_change_point = (r_sw_cnt == '0);
                // r_psel already holds the toggled value here; 0 means pass 2 has just finished.
                if (r_sw_cnt == SW_LAST) begin
                    w_next = (!r_psel && w_last_row) ? ST_DONE : ST_WAIT_ROW;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_row_words <= '0;
            r_row_num   <= '0;
            r_row_cnt   <= '0;
            r_rd_cnt    <= '0;
            r_beat_cnt  <= '0;
            r_sw_cnt    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_row_words <= row_words;
                        r_row_num   <= row_num;
                        r_row_cnt   <= '0;
                        r_rd_cnt    <= '0;
                        r_beat_cnt  <= '0;
                        r_sw_cnt    <= '0;
                        r_psel      <= 1'b0;
                    end
                end
                ST_WAIT_ROW: begin
                    r_rd_cnt   <= '0;
                    r_beat_cnt <= '0;
                    r_sw_cnt   <= '0;
                end
                ST_READ: begin
                    if (w_rden) begin
                        r_rd_cnt <= r_rd_cnt + CNT_ONE;
                    end
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + CNT_ONE;
                    end
                end
                ST_SWITCH: begin
                    if (r_sw_cnt == '0) begin
                        r_psel <= ~r_psel;
                    end
                    if (r_sw_cnt == SW_LAST) begin
                        r_sw_cnt <= '0;
                        if (!r_psel) begin
                            r_row_cnt <= r_row_cnt + ROW_ONE;
                        end
                    end else begin
                        r_sw_cnt <= r_sw_cnt + SW_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upsample_read_ctrl.sv
// Directed bench for upsample_read_ctrl with a behavioural virtual/real-pointer FIFO model.
module tb_upsample_read_ctrl;
    import upsample_read_ctrl_pkg::*;

    localparam int unsigned DW = UPS_DATA_R;
    localparam int unsigned AW = UPS_DEPTH_R;
    localparam int unsigned RW = UPS_ROWS_W;

    logic          system_clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] row_words;
    logic [RW-1:0] row_num;
    logic          busy;
    logic          done;

    upsample_read_ctrl_if #(.DATA_R(DW), .DEPTH_R(AW)) bus ();

    upsample_read_ctrl #(.DATA_R(DW), .DEPTH_R(AW), .ROWS_W(RW)) dut (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .start      (start),
        .row_words  (row_words),
        .row_num    (row_num),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 system_clk = ~system_clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    always @(posedge system_clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] wd(input int unsigned k);
        return {8'hA5, 88'h0, k};
    endfunction

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: virtual pointer reads without consuming, change_point swaps mode and resyncs it.
    logic [DW-1:0] fmem [64];
    logic [11:0]   f_wr, f_real, f_virt, f_cnt;
    logic          f_psel;
    logic          tb_push;
    logic [DW-1:0] tb_push_data;

    always_comb begin
        f_cnt                     = f_wr - (f_psel ? f_real : f_virt);
        bus.fifo_rddata           = fmem[f_psel ? f_real[5:0] : f_virt[5:0]];
        bus.fifo_empty            = (f_cnt == 12'd0);
        bus.fifo_ready_for_output = f_psel ? (f_cnt == 12'd0) : (f_cnt < {1'b0, bus.fifo_empty_thr});
    end

    always @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            f_wr <= '0; f_real <= '0; f_virt <= '0; f_psel <= 1'b0;
        end else begin
            if (tb_push) begin
                fmem[f_wr[5:0]] <= tb_push_data;
                f_wr <= f_wr + 12'd1;
            end
            if (bus.fifo_rden) begin
                if (f_psel) f_real <= f_real + 12'd1;
                else        f_virt <= f_virt + 12'd1;
            end
            if (bus.fifo_change_point) begin
                f_psel <= ~f_psel;
                f_virt <= f_real;
            end
        end
    end

    int unsigned ready_mode = 0;
    always begin
        @(posedge system_clk);
        #1;
        bus.out_ready = (ready_mode == 1) ? ~bus.out_ready : 1'b1;
    end

    typedef struct { logic [DW-1:0] d; logic rl; logic fl; } beat_t;
    beat_t beats[$];
    int unsigned cp_cnt = 0, rden_cnt = 0, done_cnt = 0;
    int unsigned collide_cnt = 0, underflow_cnt = 0, stall_err = 0;
    int unsigned last_beat_cyc = 0, done_cyc = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge system_clk) begin
        if (rst_n) begin
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stall_err++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                beats.push_back('{d: bus.out_data, rl: bus.out_row_last, fl: bus.out_frame_last});
                last_beat_cyc = cyc;
            end
            if (bus.fifo_rden) rden_cnt++;
            if (bus.fifo_change_point) cp_cnt++;
            if (bus.fifo_rden && bus.fifo_change_point) collide_cnt++;
            if (bus.fifo_rden && bus.fifo_empty) underflow_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    int unsigned snap_beats, snap_cp, snap_rden, snap_done, start_cyc;

    task automatic preload(input int unsigned k0, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge system_clk); #1;
            tb_push      = 1'b1;
            tb_push_data = wd(k0 + i);
        end
        @(negedge system_clk); #1;
        tb_push = 1'b0;
    endtask

    task automatic pulse_start(input int unsigned rw, input int unsigned rn, input string tag);
        @(negedge system_clk); #1;
        snap_beats = beats.size();
        snap_cp    = cp_cnt;
        snap_rden  = rden_cnt;
        snap_done  = done_cnt;
        start_cyc  = cyc;
        start      = 1'b1;
        row_words  = AW'(rw);
        row_num    = RW'(rn);
        @(negedge system_clk); #1;
        start = 1'b0;
        check_val({tag, "_busy"}, busy, 1);
    endtask

    task automatic wait_done(input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (done_cnt == snap_done && n < budget) begin
            @(negedge system_clk); #1;
            n++;
        end
        check_val({tag, "_done_seen"}, done_cnt != snap_done, 1);
    endtask

    task automatic compare_beats(input int unsigned rw, input int unsigned rn,
                                 input int unsigned k0, input string tag);
        int unsigned idx = snap_beats;
        logic exp_rl, exp_fl;
        check_val({tag, "_nbeats"}, beats.size() - snap_beats, 4 * rw * rn);
        for (int unsigned r = 0; r < rn; r++)
            for (int unsigned p = 0; p < 2; p++)
                for (int unsigned w = 0; w < rw; w++)
                    for (int unsigned b = 0; b < 2; b++) begin
                        if (idx < beats.size()) begin
                            exp_rl = (b == 1) && (w == rw - 1);
                            exp_fl = exp_rl && (p == 1) && (r == rn - 1);
                            check_val($sformatf("%s_d%0d", tag, idx - snap_beats), beats[idx].d, wd(k0 + r * rw + w));
                            check_val($sformatf("%s_rl%0d", tag, idx - snap_beats), beats[idx].rl, exp_rl);
                            check_val($sformatf("%s_fl%0d", tag, idx - snap_beats), beats[idx].fl, exp_fl);
                        end
                        idx++;
                    end
    endtask

    task automatic finish_frame(input int unsigned rw, input int unsigned rn,
                                input int unsigned k0, input string tag);
        wait_done(40 * rw * rn + 100, tag);
        repeat (3) begin
            @(negedge system_clk); #1;
        end
        compare_beats(rw, rn, k0, tag);
        check_val({tag, "_cp"}, cp_cnt - snap_cp, 2 * rn);
        check_val({tag, "_rden"}, rden_cnt - snap_rden, 2 * rw * rn);
        check_val({tag, "_done_once"}, done_cnt - snap_done, 1);
        check_val({tag, "_done_lat"}, (done_cyc > last_beat_cyc) && (done_cyc - last_beat_cyc <= 6), 1);
        check_val({tag, "_fifo_empty"}, bus.fifo_empty, 1);
        check_val({tag, "_psel"}, dut.r_psel, 0);
        check_val({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_valid"}, bus.out_valid, 0);
        check_val({tag, "_data"}, bus.out_data, 0);
        check_val({tag, "_rden"}, bus.fifo_rden, 0);
        check_val({tag, "_cp"}, bus.fifo_change_point, 0);
        check_val({tag, "_thr"}, bus.fifo_empty_thr, 0);
        check_val({tag, "_rl"}, bus.out_row_last, 0);
        check_val({tag, "_fl"}, bus.out_frame_last, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_psel"}, dut.r_psel, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned n, fall_cyc, first_rd, early_rd, pushed, cnt_at_rd;
        logic seen_fall, seen_rd;

        rst_n = 1'b0; start = 1'b0; row_words = '0; row_num = '0;
        tb_push = 1'b0; tb_push_data = '0; ready_mode = 0;
        repeat (3) @(negedge system_clk);
        check_outputs_zero("rst");
        rst_n = 1'b1;

        // 1: two rows of four words, out_ready held high
        preload(0, 8);
        pulse_start(4, 2, "t1");
        finish_frame(4, 2, 0, "t1");

        // 2: out_ready toggling, plus a start pulse while busy that must be ignored
        preload(8, 8);
        ready_mode = 1;
        pulse_start(4, 2, "t2");
        repeat (5) @(negedge system_clk);
        #1;
        start = 1'b1; row_words = AW'(1); row_num = RW'(7);
        @(negedge system_clk); #1;
        start = 1'b0;
        finish_frame(4, 2, 8, "t2");
        ready_mode = 0;

        // 3: slow fill, one word per five cycles, threshold four
        pulse_start(4, 1, "t3");
        fall_cyc = 0; first_rd = 0; early_rd = 0; pushed = 0; cnt_at_rd = 0;
        seen_fall = 1'b0; seen_rd = 1'b0;
        for (int unsigned i = 0; i < 120 && !seen_rd; i++) begin
            @(negedge system_clk); #1;
            if (bus.fifo_rden && !seen_fall) early_rd++;
            if (!seen_fall && !bus.fifo_ready_for_output) begin
                seen_fall = 1'b1;
                fall_cyc  = cyc;
            end
            if (bus.fifo_rden && !seen_rd) begin
                seen_rd   = 1'b1;
                first_rd  = cyc;
                cnt_at_rd = f_cnt;
            end
            tb_push = (i % 5 == 0) && (pushed < 4);
            if (tb_push) begin
                tb_push_data = wd(16 + pushed);
                pushed++;
            end
        end
        tb_push = 1'b0;
        check_val("t3_fall_seen", seen_fall, 1);
        check_val("t3_early_rden", early_rd, 0);
        check_val("t3_words_at_rd", cnt_at_rd, 4);
        check_val("t3_rd_lat", seen_rd && (first_rd >= fall_cyc) && (first_rd - fall_cyc <= 1), 1);
        finish_frame(4, 1, 16, "t3");

        // 4: single word, single row
        preload(20, 1);
        pulse_start(1, 1, "t4");
        finish_frame(1, 1, 20, "t4");

        // 5: empty frames complete immediately without touching the FIFO
        pulse_start(4, 0, "t5");
        wait_done(3, "t5");
        check_val("t5_lat", done_cyc - start_cyc <= 2, 1);
        check_val("t5_rden", rden_cnt - snap_rden, 0);
        check_val("t5_cp", cp_cnt - snap_cp, 0);
        pulse_start(0, 3, "t5b");
        wait_done(3, "t5b");
        check_val("t5b_lat", done_cyc - start_cyc <= 2, 1);
        check_val("t5b_rden", rden_cnt - snap_rden, 0);
        check_val("t5b_cp", cp_cnt - snap_cp, 0);

        // 6: reset in the middle of a row, then a clean frame
        preload(24, 8);
        pulse_start(4, 2, "t6");
        n = 0;
        while (beats.size() - snap_beats < 5 && n < 200) begin
            @(negedge system_clk); #1;
            n++;
        end
        check_val("t6_midrow", beats.size() - snap_beats >= 5, 1);
        rst_n = 1'b0;
        @(posedge system_clk); #1;
        check_outputs_zero("t6_rst");
        repeat (2) @(negedge system_clk);
        rst_n = 1'b1;
        preload(32, 8);
        pulse_start(4, 2, "t6b");
        finish_frame(4, 2, 32, "t6b");

        check_val("collide", collide_cnt, 0);
        check_val("underflow", underflow_cnt, 0);
        check_val("stall_stable", stall_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
